dds_frame_parser: RTL

Byte-stream command parser sitting directly downstream of the host-side byte FIFO. It pops bytes from the FIFO read port and recognises framed register-write commands. It checks each frame's length and XOR checksum, then presents one assembled register write (address plus up to 32-bit data) to the DDS register-programming stage with a valid/ready handshake. Malformed frames are dropped, counted, and the parser resynchronises on the next sync byte.

---
 rtl/dds_frame_pkg.sv | 23 ++
 rtl/dds_frame_accum.sv | 44 ++++
 rtl/dds_frame_parser.sv | 101 ++++++++++
 3 files changed

// File: rtl/dds_frame_pkg.sv
// Shared types and defaults for the DDS host-command frame parser.
// The frame state encoding, the default framing constants and the payload-length rule live here.
package dds_frame_pkg;

  typedef enum logic [2:0] {
    SYNC,
    ADDR,
    LEN,
    DATA,
    CSUM,
    OUT
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MAX_LEN_DEF   = 4;
  localparam int         ERR_CNT_W     = 8;

  // A payload length is usable when it is non-zero and fits the data register.
  function automatic logic len_ok(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/dds_frame_accum.sv
// Payload datapath for the frame parser.
// It holds the MSB-first data shift register, the remaining-byte counter and the running XOR checksum.
module dds_frame_accum
  import dds_frame_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic        read_clk,
  input  logic        rst_read_flag,
  input  logic        clear,
  input  logic        load,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] data,
  output logic [7:0]  csum,
  output logic        last_byte
);

  logic [CNT_W-1:0] remaining;

  // clear seeds the checksum from the address byte; load takes the length byte and empties the data register.
  always_ff @(posedge read_clk or posedge rst_read_flag) begin
    if (rst_read_flag) begin
      data      <= '0;
      csum      <= '0;
      remaining <= '0;
    end else if (clear) begin
      data      <= '0;
      csum      <= byte_in;
      remaining <= '0;
    end else if (load) begin
      data      <= '0;
      csum      <= csum ^ byte_in;
      remaining <= byte_in[CNT_W-1:0];
    end else if (shift) begin
      data      <= {data[23:0], byte_in};
      csum      <= csum ^ byte_in;
      remaining <= remaining - 1'b1;
    end
  end

  assign last_byte = (remaining == CNT_W'(1));

endmodule

// File: rtl/dds_frame_parser.sv
// Pops bytes from the host FIFO, parses sync/addr/len/data/csum frames.
// Each good frame becomes one register write; malformed frames are dropped and counted.
module dds_frame_parser
  import dds_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_LEN   = MAX_LEN_DEF
) (
  input  logic                 read_clk,
  input  logic                 rst_read_flag,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [7:0]           wr_addr,
  output logic [31:0]          wr_data,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_t     state;
  logic       take;
  logic       len_good;
  logic       csum_good;
  logic       err_now;
  logic       acc_clear;
  logic       acc_load;
  logic       acc_shift;
  logic       last_byte;
  logic [7:0] csum;

  assign take      = byte_valid && byte_ready;
  assign len_good  = len_ok(byte_in, MAX_LEN);
  assign csum_good = (byte_in == csum);
  assign err_now   = take && (((state == LEN) && !len_good) ||
                              ((state == CSUM) && !csum_good));
  assign acc_clear = take && (state == ADDR);
  assign acc_load  = take && (state == LEN) && len_good;
  assign acc_shift = take && (state == DATA);

  dds_frame_accum #(
    .CNT_W(CNT_W)
  ) u_accum (
    .read_clk     (read_clk),
    .rst_read_flag(rst_read_flag),
    .clear        (acc_clear),
    .load         (acc_load),
    .shift        (acc_shift),
    .byte_in      (byte_in),
    .data         (wr_data),
    .csum         (csum),
    .last_byte    (last_byte)
  );

  // byte_ready is registered: it drops on the edge that enters OUT and returns on the handshake edge.
  always_ff @(posedge read_clk or posedge rst_read_flag) begin
    if (rst_read_flag) begin
      state      <= SYNC;
      byte_ready <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      err_pulse  <= err_now;
      if (err_now && (err_cnt != {ERR_CNT_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
      byte_ready <= 1'b1;
      case (state)
        SYNC: if (take && (byte_in == SYNC_BYTE)) state <= ADDR;
        ADDR: if (take) begin
          wr_addr <= byte_in;
          state   <= LEN;
        end
        LEN:  if (take) state <= len_good ? DATA : SYNC;
        DATA: if (take && last_byte) state <= CSUM;
        CSUM: if (take) begin
          if (csum_good) begin
            state      <= OUT;
            wr_valid   <= 1'b1;
            byte_ready <= 1'b0;
          end else begin
            state <= SYNC;
          end
        end
        OUT: begin
          byte_ready <= wr_ready;
          if (wr_ready) begin
            wr_valid <= 1'b0;
            state    <= SYNC;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule
